alarm_time_setter: RTL
======================

Name: alarm_time_setter

Overview:
- Upstream stage of the alarm-clock controller. Produces the four BCD alarm digits (num0 = seconds ones, num1 = seconds tens, num2 = minutes ones, num3 = minutes tens) that feed the alarm-load decoding and alarm-match logic.
- Turns four raw push-buttons into debounced single-cycle events.
- Runs a digit-edit state machine on a shadow copy of the alarm time.
- Commits the edited time atomically and sets an armed flag.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: my_clock cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz).
- REPEAT_DELAY, 50_000_000: hold time before auto-repeat starts. Used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 20_000_000: auto-repeat interval once repeat has started. Used only with AUTO_REPEAT_EN.

Ports:
- my_clock, input, 1: system clock.
- Resetn, input, 1: asynchronous, active-high reset.
- btn_set, input, 1: raw button. Enter edit / commit.
- btn_next, input, 1: raw button. Select next digit / toggle armed.
- btn_up, input, 1: raw button. Increment selected digit.
- btn_down, input, 1: raw button. Decrement selected digit.
- num0, output, 4: committed seconds ones, BCD 0-9.
- num1, output, 4: committed seconds tens, BCD 0-5.
- num2, output, 4: committed minutes ones, BCD 0-9.
- num3, output, 4: committed minutes tens, BCD 0-5.
- armed, output, 1: alarm enabled.
- editing, output, 1: FSM is in an edit state.
- edit_digit, output, 2: index of the digit being edited (0 = num0 … 3 = num3). Valid while editing = 1.

Behaviour:
- Reset (asynchronous, Resetn = 1):
  - FSM goes to IDLE.
  - num0..num3 = 0, shadow digits = 0, armed = 0, editing = 0, edit_digit = 3.
  - Synchronizers, debounce counters and debounced levels all clear to 0.
  - Reset asserted mid-edit discards the shadow values.
- Input conditioning, per button:
  - 2-flop synchronizer, then a stability counter.
  - The counter clears whenever the synchronized level differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized level.
  - A rising edge of the debounced level produces a 1-cycle event pulse.
  - Latency from a clean press to the event: DEBOUNCE_CYCLES + 3 cycles.
  - A pulse shorter than DEBOUNCE_CYCLES produces no event.
- Event priority when several events fall in one cycle: set > next > up/down. If up and down fire together, both are ignored.
- FSM states: IDLE, EDIT_M1, EDIT_M0, EDIT_S1, EDIT_S0.
- IDLE:
  - set: copy num0..num3 into the shadow registers, go to EDIT_M1.
  - next: toggle armed.
  - up/down: ignored.
- Any EDIT state:
  - next: advance M1 -> M0 -> S1 -> S0 -> M1 (wraps).
  - up: the selected shadow digit increments. Ones digits wrap 9 -> 0, tens digits wrap 5 -> 0.
  - down: the selected shadow digit decrements. Ones digits wrap 0 -> 9, tens digits wrap 0 -> 5.
  - set: in one cycle, copy the shadow into num0..num3, set armed = 1, go to IDLE.
  - Digit arithmetic is modulo its own limit only. No carry or borrow into the neighbouring digit.
- While editing, num0..num3 and armed keep their committed values, so a running alarm comparison never sees partial edits.
- editing = 1 in any EDIT state.
- edit_digit: EDIT_S0 = 0, EDIT_S1 = 1, EDIT_M0 = 2, EDIT_M1 = 3.
- All outputs are registered. A committed value is visible the cycle after the set event.
- num outputs never leave the legal BCD range for their position.

Optional Feature:
- Macro: ALARM_SETTER_AUTO_REPEAT_EN.
- Defined:
  - In an EDIT state, a debounced up or down level held continuously for REPEAT_DELAY cycles after its event generates further events every REPEAT_PERIOD cycles.
  - Releasing the button, or any set/next event, clears the repeat timer.
  - Up and down held together generate no repeats.
- Not defined: one event per press only. No repeat counters are synthesized, and REPEAT_DELAY / REPEAT_PERIOD are unused.

Test Plan (DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_PERIOD = 8):
- Reset, then idle 50 cycles -> num3..num0 = 0,0,0,0; armed = 0; editing = 0.
- Press set; up ×2; next; up ×7; next; down ×1; next; up ×9; set -> num3 = 2, num2 = 7, num1 = 5, num0 = 9, armed = 1. Outputs hold 0000 until the commit cycle.
- Glitch btn_up high for 3 cycles while in EDIT_M1 -> no change to the shadow digit. A 6-cycle press -> exactly one increment, seen DEBOUNCE_CYCLES + 3 cycles after the press.
- Wrap checks:
  - EDIT_M1 at 5, up -> 0.
  - EDIT_S0 at 0, down -> 9.
  - next ×4 from EDIT_M1 -> returns to EDIT_M1 (edit_digit = 3).
- Assert Resetn mid-edit after shadow changes -> num = 0000, armed = 0, FSM in IDLE. Then set, set -> commits 0000 and armed = 1. In IDLE, next -> armed = 0.
- With ALARM_SETTER_AUTO_REPEAT_EN, hold btn_up 60 cycles in EDIT_S0 starting at 0 -> digit reaches 1 + floor((60-4-3-20)/8)+1, checked against the model. Without the macro -> digit = 1.

Source files
------------

// File: rtl/alarm_time_setter.sv
// Alarm time setter: debounces four raw buttons, edits a shadow copy of the
// alarm time digit by digit, and commits it atomically with the armed flag.
// Optional build macro ALARM_SETTER_AUTO_REPEAT_EN adds hold-to-repeat on
// up/down while editing; without it every press yields exactly one event.
module alarm_time_setter #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned REPEAT_DELAY    = 50_000_000,
   parameter int unsigned REPEAT_PERIOD   = 20_000_000
) (
   input  logic       my_clock,
   input  logic       Resetn,
   input  logic       btn_set,
   input  logic       btn_next,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [3:0] num0,
   output logic [3:0] num1,
   output logic [3:0] num2,
   output logic [3:0] num3,
   output logic       armed,
   output logic       editing,
   output logic [1:0] edit_digit
);

   localparam int unsigned NBTN   = 4;
   localparam int unsigned B_SET  = 0;
   localparam int unsigned B_NEXT = 1;
   localparam int unsigned B_UP   = 2;
   localparam int unsigned B_DOWN = 3;

   localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   // Zero-length timing knobs would make the counters wrap instead of expire.
   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("alarm_time_setter: timing parameters must be at least 1");
   end

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      EDIT_M1 = 3'd1,
      EDIT_M0 = 3'd2,
      EDIT_S1 = 3'd3,
      EDIT_S0 = 3'd4
   } state_t;

   state_t          state;
   logic [3:0]      shadow [4];

   logic [NBTN-1:0] raw;
   logic [NBTN-1:0] sync1;
   logic [NBTN-1:0] sync2;
   logic [NBTN-1:0] db;
   logic [NBTN-1:0] db_d;
   logic [DB_W-1:0] db_cnt [NBTN];
   logic [NBTN-1:0] evt;

   logic            rep_up;
   logic            rep_dn;
   logic            do_up;
   logic            do_dn;

   assign raw = {btn_down, btn_up, btn_next, btn_set};

   // Synchronize each button and accept a new level only after it has been
   // stable for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge my_clock or posedge Resetn) begin
      if (Resetn) begin
         sync1 <= '0;
         sync2 <= '0;
         db    <= '0;
         db_d  <= '0;
         for (int i = 0; i < NBTN; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         db_d  <= db;
         for (int i = 0; i < NBTN; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // One-cycle event on each rising edge of a debounced level.
   assign evt = db & ~db_d;

`ifdef ALARM_SETTER_AUTO_REPEAT_EN
   localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;
   localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);

   logic [RP_W-1:0] rep_cnt;
   logic            rep_started;
   logic            rep_hold;
   logic            rep_fire;

   // Repeat only while exactly one of up/down is held in an edit state and no
   // fresh event is restarting the timer this cycle.
   assign rep_hold = editing && (db[B_UP] ^ db[B_DOWN]) && (evt == '0);
   assign rep_fire = rep_hold && (rep_started ? (rep_cnt == RP_LAST) : (rep_cnt == RD_LAST));
   assign rep_up   = rep_fire & db[B_UP];
   assign rep_dn   = rep_fire & db[B_DOWN];

   // Hold timer: initial delay first, then the repeat period.
   always_ff @(posedge my_clock or posedge Resetn) begin
      if (Resetn) begin
         rep_cnt     <= '0;
         rep_started <= 1'b0;
      end else if (!rep_hold) begin
         rep_cnt     <= '0;
         rep_started <= 1'b0;
      end else if (rep_fire) begin
         rep_cnt     <= '0;
         rep_started <= 1'b1;
      end else begin
         rep_cnt     <= rep_cnt + RP_W'(1);
      end
   end
`else
   assign rep_up = 1'b0;
   assign rep_dn = 1'b0;
`endif

   // Simultaneous up and down events cancel each other.
   assign do_up = (evt[B_UP] & ~evt[B_DOWN]) | rep_up;
   assign do_dn = (evt[B_DOWN] & ~evt[B_UP]) | rep_dn;

   // Ones digits roll over at 9, tens digits at 5; no carry between digits.
   function automatic logic [3:0] step_digit(input logic [3:0] d, input logic inc,
                                             input logic tens);
      logic [3:0] top;
      top = tens ? 4'd5 : 4'd9;
      if (inc) begin
         step_digit = (d >= top) ? 4'd0 : d + 4'd1;
      end else begin
         step_digit = ((d == 4'd0) || (d > top)) ? top : d - 4'd1;
      end
   endfunction

   function automatic state_t advance(input state_t s);
      case (s)
         EDIT_M1: advance = EDIT_M0;
         EDIT_M0: advance = EDIT_S1;
         EDIT_S1: advance = EDIT_S0;
         default: advance = EDIT_M1;
      endcase
   endfunction

   function automatic logic [1:0] digit_of(input state_t s);
      case (s)
         EDIT_S0: digit_of = 2'd0;
         EDIT_S1: digit_of = 2'd1;
         EDIT_M0: digit_of = 2'd2;
         default: digit_of = 2'd3;
      endcase
   endfunction

   // Edit FSM: shadow digits change freely, committed outputs only on set.
   always_ff @(posedge my_clock or posedge Resetn) begin
      if (Resetn) begin
         state      <= IDLE;
         shadow[0]  <= 4'd0;
         shadow[1]  <= 4'd0;
         shadow[2]  <= 4'd0;
         shadow[3]  <= 4'd0;
         num0       <= 4'd0;
         num1       <= 4'd0;
         num2       <= 4'd0;
         num3       <= 4'd0;
         armed      <= 1'b0;
         editing    <= 1'b0;
         edit_digit <= 2'd3;
      end else begin
         case (state)
            IDLE: begin
               if (evt[B_SET]) begin
                  shadow[0]  <= num0;
                  shadow[1]  <= num1;
                  shadow[2]  <= num2;
                  shadow[3]  <= num3;
                  state      <= EDIT_M1;
                  editing    <= 1'b1;
                  edit_digit <= digit_of(EDIT_M1);
               end else if (evt[B_NEXT]) begin
                  armed <= ~armed;
               end
            end
            EDIT_M1, EDIT_M0, EDIT_S1, EDIT_S0: begin
               if (evt[B_SET]) begin
                  num0    <= shadow[0];
                  num1    <= shadow[1];
                  num2    <= shadow[2];
                  num3    <= shadow[3];
                  armed   <= 1'b1;
                  editing <= 1'b0;
                  state   <= IDLE;
               end else if (evt[B_NEXT]) begin
                  state      <= advance(state);
                  edit_digit <= digit_of(advance(state));
               end else if (do_up) begin
                  shadow[edit_digit] <= step_digit(shadow[edit_digit], 1'b1, edit_digit[0]);
               end else if (do_dn) begin
                  shadow[edit_digit] <= step_digit(shadow[edit_digit], 1'b0, edit_digit[0]);
               end
            end
            default: begin
               state   <= IDLE;
               editing <= 1'b0;
            end
         endcase
      end
   end

endmodule
